pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86 core. Every cycle it produces the stall and bubble controls for the F, D, E, M and W pipeline registers, including the EX/MEM register. It covers data and control hazards (load/use, mispredicted jump, ret) and adds sequential handling for a variable-latency data memory: wait, timeout, halt freeze, and a stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_hazard.sv | 24 ++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86 encodings, widths and FSM state type for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned WordW = 32;

  typedef logic [ByteW-1:0] byte_t;

  localparam byte_t IHALT   = 8'h0;
  localparam byte_t INOP    = 8'h1;
  localparam byte_t IRRMOVL = 8'h2;
  localparam byte_t IIRMOVL = 8'h3;
  localparam byte_t IRMMOVL = 8'h4;
  localparam byte_t IMRMOVL = 8'h5;
  localparam byte_t IOPL    = 8'h6;
  localparam byte_t JXX     = 8'h7;
  localparam byte_t ICALL   = 8'h8;
  localparam byte_t IRET    = 8'h9;
  localparam byte_t IPUSHL  = 8'hA;
  localparam byte_t IPOPL   = 8'hB;
  localparam byte_t RNONE   = 8'hF;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalted  = 2'd2,
    StError   = 2'd3
  } state_e;

  function automatic logic is_mem_op(byte_t icode);
    return icode inside {IRMMOVL, IMRMOVL, ICALL, IRET, IPUSHL, IPOPL};
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signals seen by the control unit: stage icodes in, stall/bubble controls out.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  pipe_ctrl_pkg::byte_t D_icode, E_icode, M_icode, W_icode;
  pipe_ctrl_pkg::byte_t E_dstM, d_srcA, d_srcB;
  logic                 e_Cnd;
  logic                 dmem_ready;

  logic F_stall, D_stall, E_stall, M_stall;
  logic D_bubble, E_bubble, M_bubble, W_bubble;
  logic halted, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB, e_Cnd, dmem_ready,
    input  F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble,
    input  halted, mem_err, stall_cycles
  );

  modport slave (
    input  D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB, e_Cnd, dmem_ready,
    output F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble,
    output halted, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard.sv
// Raw hazard detection: load/use, mispredicted jump and ret in flight. Purely combinational.
module pipe_hazard
  import pipe_ctrl_pkg::*;
(
  input  byte_t D_icode_i,
  input  byte_t E_icode_i,
  input  byte_t M_icode_i,
  input  byte_t E_dstM_i,
  input  byte_t d_srcA_i,
  input  byte_t d_srcB_i,
  input  logic  e_Cnd_i,
  output logic  load_use_o,
  output logic  mispredict_o,
  output logic  ret_o
);

  always_comb begin
    load_use_o   = (E_icode_i inside {IMRMOVL, IPOPL}) && (E_dstM_i != RNONE) &&
                   ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    mispredict_o = (E_icode_i == JXX) && !e_Cnd_i;
    ret_o        = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline control: hazard responses, variable-latency memory wait with timeout,
// halt freeze and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               halted_q, halted_d;
  logic               mem_err_q, mem_err_d;

  logic load_use, mispredict, ret, mem_wait;
  logic f_stall, d_stall, e_stall, m_stall;
  logic d_bubble, e_bubble, m_bubble, w_bubble;

  pipe_hazard u_hazard (
    .D_icode_i    (bus.D_icode),
    .E_icode_i    (bus.E_icode),
    .M_icode_i    (bus.M_icode),
    .E_dstM_i     (bus.E_dstM),
    .d_srcA_i     (bus.d_srcA),
    .d_srcB_i     (bus.d_srcB),
    .e_Cnd_i      (bus.e_Cnd),
    .load_use_o   (load_use),
    .mispredict_o (mispredict),
    .ret_o        (ret)
  );

  assign mem_wait = is_mem_op(bus.M_icode) && !bus.dmem_ready;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    f_stall    = 1'b0;
    d_stall    = 1'b0;
    e_stall    = 1'b0;
    m_stall    = 1'b0;
    d_bubble   = 1'b0;
    e_bubble   = 1'b0;
    m_bubble   = 1'b0;
    w_bubble   = 1'b0;

    if (rst) begin
      // Flush every stage register while the FSM restarts.
      d_bubble   = 1'b1;
      e_bubble   = 1'b1;
      m_bubble   = 1'b1;
      w_bubble   = 1'b1;
      state_d    = StRun;
      wait_cnt_d = '0;
    end else if (state_q == StHalted || state_q == StError) begin
      {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
      w_bubble = 1'b1;
    end else if (mem_wait) begin
      {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
      w_bubble   = 1'b1;
      wait_cnt_d = wait_cnt_q + WaitW'(1);
      state_d    = (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) ? StError : StMemWait;
    end else begin
      state_d    = StRun;
      wait_cnt_d = '0;
      if (bus.M_icode == IHALT || bus.W_icode == IHALT) m_bubble = 1'b1;
      if (bus.W_icode == IHALT) state_d = StHalted;
      // A concurrent load/use converts the ret D bubble into a D stall.
      f_stall  = load_use | ret;
      d_stall  = load_use;
      d_bubble = mispredict | (ret & ~load_use);
      e_bubble = load_use | mispredict;
    end

    stall_cycles_d = stall_cycles_q;
    if (f_stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    halted_d  = halted_q  | (state_d == StHalted);
    mem_err_d = mem_err_q | (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      halted_q       <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      halted_q       <= halted_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign bus.F_stall      = f_stall;
  assign bus.D_stall      = d_stall;
  assign bus.E_stall      = e_stall;
  assign bus.M_stall      = m_stall;
  assign bus.D_bubble     = d_bubble;
  assign bus.E_bubble     = e_bubble;
  assign bus.M_bubble     = m_bubble;
  assign bus.W_bubble     = w_bubble;
  assign bus.halted       = halted_q;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, memory wait/timeout, halt freeze and reset recovery.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  // Control vector order: {F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, M_bubble, W_bubble}
  localparam logic [7:0] CNone    = 8'h00;
  localparam logic [7:0] CRst     = 8'h0F;
  localparam logic [7:0] CFreeze  = 8'hF1;
  localparam logic [7:0] CLoadUse = 8'hC4;
  localparam logic [7:0] CMisRet  = 8'h8C;
  localparam logic [7:0] CRet     = 8'h88;
  localparam logic [7:0] CMBub    = 8'h02;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ctrl;
  assign ctrl = {bus.F_stall, bus.D_stall, bus.E_stall, bus.M_stall,
                 bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_bubble};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    bus.D_icode    = INOP;
    bus.E_icode    = INOP;
    bus.M_icode    = INOP;
    bus.W_icode    = INOP;
    bus.E_dstM     = RNONE;
    bus.d_srcA     = RNONE;
    bus.d_srcB     = RNONE;
    bus.e_Cnd      = 1'b1;
    bus.dmem_ready = 1'b1;
  endtask

  task automatic set_load_use_ret();
    bus.E_icode = IMRMOVL;
    bus.E_dstM  = 8'h3;
    bus.d_srcA  = 8'h3;
    bus.D_icode = IRET;
  endtask

  initial begin
    rst = 1'b1;
    set_nop();
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(CRst));
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ctrl", 32'(ctrl), 32'(CNone));
    check("post_rst_cnt", bus.stall_cycles, 32'd0);
    check("post_rst_halted", 32'(bus.halted), 32'd0);
    check("post_rst_mem_err", 32'(bus.mem_err), 32'd0);

    // Hazard patterns, one cycle each.
    bus.E_icode = IMRMOVL; bus.E_dstM = 8'h3; bus.d_srcA = 8'h3; #1;
    check("load_use_srcA", 32'(ctrl), 32'(CLoadUse));
    tick(); set_nop();
    bus.E_icode = IPOPL; bus.E_dstM = 8'h5; bus.d_srcB = 8'h5; #1;
    check("load_use_srcB", 32'(ctrl), 32'(CLoadUse));
    tick(); set_nop();
    bus.E_icode = IMRMOVL; bus.E_dstM = RNONE; bus.d_srcA = RNONE; #1;
    check("load_rnone", 32'(ctrl), 32'(CNone));
    tick(); set_nop();
    bus.E_icode = JXX; bus.e_Cnd = 1'b0; bus.D_icode = IRET; #1;
    check("mispredict_ret", 32'(ctrl), 32'(CMisRet));
    tick(); set_nop();
    bus.E_icode = JXX; bus.e_Cnd = 1'b1; #1;
    check("jump_taken", 32'(ctrl), 32'(CNone));
    tick(); set_nop();
    set_load_use_ret(); #1;
    check("ret_load_use", 32'(ctrl), 32'(CLoadUse));
    tick(); set_nop(); #1;
    check("stall_cnt_hazards", bus.stall_cycles, 32'd4);

    // Memory wait: three low cycles, then ready on the timeout cycle with a ret in D.
    bus.M_icode = IMRMOVL; bus.dmem_ready = 1'b0; #1;
    check("wait1", 32'(ctrl), 32'(CFreeze));
    tick();
    set_load_use_ret(); #1;
    check("wait2_suppress", 32'(ctrl), 32'(CFreeze));
    tick();
    bus.E_icode = INOP; bus.E_dstM = RNONE; bus.d_srcA = RNONE; bus.D_icode = INOP; #1;
    check("wait3", 32'(ctrl), 32'(CFreeze));
    tick();
    bus.dmem_ready = 1'b1; bus.D_icode = IRET; #1;
    check("wait_release_ret", 32'(ctrl), 32'(CRet));
    tick(); set_nop(); #1;
    check("wait_mem_err", 32'(bus.mem_err), 32'd0);
    check("wait_done_ctrl", 32'(ctrl), 32'(CNone));
    check("stall_cnt_wait", bus.stall_cycles, 32'd8);

    // Timeout: four low cycles push the unit into ERROR.
    bus.M_icode = IMRMOVL; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("timeout_wait%0d", i), 32'(ctrl), 32'(CFreeze));
      check($sformatf("timeout_err%0d", i), 32'(bus.mem_err), 32'd0);
      tick();
    end
    set_nop(); #1;
    check("error_mem_err", 32'(bus.mem_err), 32'd1);
    check("error_freeze", 32'(ctrl), 32'(CFreeze));
    tick();
    set_load_use_ret(); #1;
    check("error_hold", 32'(ctrl), 32'(CFreeze));
    check("stall_cnt_error", bus.stall_cycles, 32'd13);
    tick();

    // Reset out of ERROR.
    set_nop(); rst = 1'b1; #1;
    check("rst_err_ctrl", 32'(ctrl), 32'(CRst));
    tick();
    rst = 1'b0; #1;
    check("rst_err_mem_err", 32'(bus.mem_err), 32'd0);
    check("rst_err_cnt", bus.stall_cycles, 32'd0);
    bus.E_icode = IMRMOVL; bus.E_dstM = 8'h3; bus.d_srcA = 8'h3; #1;
    check("rst_err_run", 32'(ctrl), 32'(CLoadUse));
    tick(); set_nop();

    // Halt: M halt squashes only; W halt freezes the core on the next cycle.
    bus.M_icode = IHALT; #1;
    check("halt_in_m", 32'(ctrl), 32'(CMBub));
    tick();
    check("halt_in_m_flag", 32'(bus.halted), 32'd0);
    bus.M_icode = INOP; bus.W_icode = IHALT; #1;
    check("halt_in_w", 32'(ctrl), 32'(CMBub));
    check("halt_in_w_flag", 32'(bus.halted), 32'd0);
    tick();
    check("halted_flag", 32'(bus.halted), 32'd1);
    set_load_use_ret(); bus.e_Cnd = 1'b0; #1;
    check("halted_freeze", 32'(ctrl), 32'(CFreeze));
    tick(); set_nop(); #1;
    check("halted_hold", 32'(ctrl), 32'(CFreeze));
    check("halted_sticky", 32'(bus.halted), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rst_halt_flag", 32'(bus.halted), 32'd0);

    // Reset while in MEM_WAIT.
    bus.M_icode = IMRMOVL; bus.dmem_ready = 1'b0; #1;
    check("mw_wait", 32'(ctrl), 32'(CFreeze));
    tick();
    rst = 1'b1; #1;
    check("mw_rst_ctrl", 32'(ctrl), 32'(CRst));
    tick();
    rst = 1'b0; set_nop(); #1;
    check("mw_rst_ctrl_after", 32'(ctrl), 32'(CNone));
    check("mw_rst_cnt", bus.stall_cycles, 32'd0);
    check("mw_rst_mem_err", 32'(bus.mem_err), 32'd0);
    // A stale wait count would trip the timeout within these three cycles.
    bus.M_icode = IMRMOVL; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.dmem_ready = 1'b1; #1;
    check("mw_rst_no_err", 32'(bus.mem_err), 32'd0);
    check("mw_rst_release", 32'(ctrl), 32'(CNone));
    tick(); set_nop(); #1;
    check("mw_rst_no_err2", 32'(bus.mem_err), 32'd0);
    check("mw_rst_cnt2", bus.stall_cycles, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
